tick_scheduler: RTL
===================

Name: tick_scheduler

Overview:
- Multi-channel clock-enable scheduler: generates single-cycle tick strobes on NUM_CH independent channels from the one system clock. Typical consumers are the VGA pixel enable, the input debounce sampler and the display blink timer.
- Replaces per-consumer derived clocks with enables, so the whole design stays in one clock domain.
- Each channel's divide ratio is reconfigurable at runtime through a valid/ready port.
- New ratios take effect only on a tick boundary, so no strobe is ever shortened or glitched.

Parameters:
- NUM_CH, 4, number of tick channels (1..16).
- DIV_W, 16, width of each divide ratio.
- DEFAULT_DIV, 2, divide ratio loaded into every channel at reset (50 MHz -> 25 MHz pixel enable).

Ports:
- clk_i  in  1  system clock; all logic on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- en_i  in  NUM_CH  per-channel run enable.
- sync_i  in  1  restarts all channel counters together (phase alignment).
- cfg_valid_i  in  1  config request valid.
- cfg_ready_o  out  1  config request ready.
- cfg_ch_i  in  CH_W  target channel, where CH_W = max(1, $clog2(NUM_CH)).
- cfg_div_i  in  DIV_W  new divide ratio N.
- tick_o  out  NUM_CH  registered one-cycle tick strobes.
- div_o  out  NUM_CH*DIV_W  active ratio per channel; channel k occupies bits [k*DIV_W +: DIV_W].

Behaviour:
- Reset (rst_i high at a clock edge):
  - tick_o=0, every counter=0, every active ratio=DEFAULT_DIV, every pending flag=0.
  - cfg_err_o=0 when present.
  - Reset aborts any pending update.
- Priority at each edge: rst_i > sync_i > normal operation.
- Ratio meaning:
  - N>=1: one tick every N cycles.
  - N=1: tick_o high continuously while enabled.
  - N=0: channel parked. Counter held at 0, no ticks, regardless of en_i.
- Per-channel counter, normal operation:
  - en_i[k]=0 or N=0: counter is 0 and tick_o[k]=0 on the next cycle.
  - en_i[k]=1 and N>0:
    - counter==N-1: counter <= 0, tick_o[k] <= 1.
    - otherwise: counter <= counter+1, tick_o[k] <= 0.
- Latency: after en_i[k] rises, with the counter at 0, tick_o[k] first goes high on the Nth edge sampling en_i[k]=1. It then repeats every N cycles.
- Dropping en_i mid-count discards the partial count. There is no resume.
- sync_i=1:
  - All counters <= 0 and all tick_o <= 0 for that cycle.
  - All pending updates apply immediately.
  - The next tick on channel k comes N cycles after sync_i falls, if enabled.
- Config handshake:
  - cfg_ready_o = !pending[cfg_ch_i]. It is combinational from cfg_ch_i and pending, with no dependence on cfg_valid_i.
  - Out-of-range channels always read ready.
  - Transfer occurs when cfg_valid_i && cfg_ready_o at an edge. cfg_div_i is then stored in channel shadow[k] and pending[k] <= 1.
- Pending update applies (active <= shadow, pending <= 0) at the first of:
  - the wrap edge of channel k (the same edge tick_o[k] is set);
  - any edge where channel k is idle (en_i[k]=0 or active N=0);
  - sync_i.
  The new ratio governs the count starting immediately after that edge.
- Simultaneous events:
  - A transfer on the wrap edge of its own channel does not apply at that edge; it applies at the following wrap.
  - A transfer while rst_i is high is discarded.
- Out-of-range channel (cfg_ch_i >= NUM_CH): accepted and dropped. No state changes.
- div_o reflects active ratios, never shadow values.
- Counters are DIV_W bits wide. No counter ever exceeds N-1, so there is no overflow path.

Optional Feature:
- Macro: TICK_SCHED_CFG_CHK_EN.
- Defined:
  - Adds output port cfg_err_o (1 bit, reset 0).
  - cfg_err_o pulses high for exactly one cycle, on the edge after an accepted transfer whose cfg_ch_i >= NUM_CH.
  - Write data is still dropped.
- Undefined: cfg_err_o port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then en_i=4'b0001 with DEFAULT_DIV=2 -> tick_o[0] toggles 1,0,1,0 with first high 2 edges after en; div_o channel0 = 2; other ticks 0.
- Ch1 at N=5 running; write N=3 to ch1 at count 2 -> ticks keep 5-cycle spacing until the next wrap, then 3-cycle spacing; cfg_ready_o low for ch1 until that wrap; no short pulse.
- Ch2 disabled; write N=0 -> applies next edge, div_o=0, no ticks after en_i[2]=1; then write N=1 -> tick_o[2] high every cycle.
- Ch0 N=4 and ch3 N=6 running at arbitrary phases; pulse sync_i one cycle -> all ticks 0 that cycle; ch0 ticks at +4, +8; ch3 ticks at +6 after sync falls.
- Transfer on ch1's exact wrap edge with N=4->7 -> next interval still 4, then 7; assert rst_i mid-pending -> div_o back to DEFAULT_DIV, ready high.
- With TICK_SCHED_CFG_CHK_EN and NUM_CH=3: write cfg_ch_i=3 -> accepted, cfg_err_o=1 for one cycle next edge, all div_o unchanged; without the macro -> same drop, no port.

Source files
------------

// File: rtl/tick_scheduler.sv
// Multi-channel clock-enable scheduler: NUM_CH single-cycle tick strobes, runtime divide ratios.
// Latency: tick_o[k] is registered; the first tick lands on the Nth edge that samples en_i[k]=1.
// Backpressure: cfg_ready_o drops for a channel while its ratio update waits for a tick boundary.
// Optional: define TICK_SCHED_CFG_CHK_EN to add cfg_err_o (out-of-range channel write flag).
module tick_scheduler #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 2,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic                    sync_i,
  input  logic                    cfg_valid_i,
  output logic                    cfg_ready_o,
  input  logic [CH_W-1:0]         cfg_ch_i,
  input  logic [DIV_W-1:0]        cfg_div_i,
  output logic [NUM_CH-1:0]       tick_o,
  output logic [NUM_CH*DIV_W-1:0] div_o
`ifdef TICK_SCHED_CFG_CHK_EN
  ,
  output logic                    cfg_err_o
`endif
);

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

  // Per-channel state: counter, active ratio, shadow ratio, pending flag, tick strobe.
  logic [DIV_W-1:0]  cnt_q [NUM_CH];
  logic [DIV_W-1:0]  cnt_d [NUM_CH];
  logic [DIV_W-1:0]  act_q [NUM_CH];
  logic [DIV_W-1:0]  act_d [NUM_CH];
  logic [DIV_W-1:0]  shd_q [NUM_CH];
  logic [DIV_W-1:0]  shd_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q;
  logic [NUM_CH-1:0] pend_d;
  logic [NUM_CH-1:0] tick_q;
  logic [NUM_CH-1:0] tick_d;

  logic [NUM_CH-1:0] wr_sel;
  logic [NUM_CH-1:0] idle;
  logic [NUM_CH-1:0] wrap;
  logic              cfg_xfer;

  // Config decode: ready reflects only the addressed channel's pending flag.
  // Channels beyond NUM_CH match nothing, so they read ready and write nowhere.
  always_comb begin
    cfg_ready_o = 1'b1;
    wr_sel      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cfg_ch_i == CH_W'(k)) begin
        cfg_ready_o = !pend_q[k];
      end
    end
    cfg_xfer = cfg_valid_i && cfg_ready_o;
    for (int k = 0; k < NUM_CH; k++) begin
      wr_sel[k] = cfg_xfer && (cfg_ch_i == CH_W'(k));
    end
  end

  // Channel next-state: count, wrap/tick, and ratio updates applied only on a boundary.
  // A write can only land on a channel with no pending update, so the apply path
  // (which clears pending) and the write path (which sets it) never collide; a write
  // on a wrap or idle edge therefore waits for the next boundary.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      cnt_d[k]  = cnt_q[k];
      act_d[k]  = act_q[k];
      shd_d[k]  = shd_q[k];
      pend_d[k] = pend_q[k];
      tick_d[k] = 1'b0;
      idle[k]   = !en_i[k] || (act_q[k] == '0);
      wrap[k]   = !idle[k] && (cnt_q[k] == act_q[k] - DIV_W'(1));

      if (sync_i || idle[k]) begin
        cnt_d[k] = '0;
        if (pend_q[k]) begin
          act_d[k]  = shd_q[k];
          pend_d[k] = 1'b0;
        end
      end else if (wrap[k]) begin
        cnt_d[k]  = '0;
        tick_d[k] = 1'b1;
        if (pend_q[k]) begin
          act_d[k]  = shd_q[k];
          pend_d[k] = 1'b0;
        end
      end else begin
        cnt_d[k] = cnt_q[k] + DIV_W'(1);
      end

      if (wr_sel[k]) begin
        shd_d[k]  = cfg_div_i;
        pend_d[k] = 1'b1;
      end
    end
  end

  // State registers; reset restores default ratios and drops any pending update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
      tick_q <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_q[k] <= '0;
        act_q[k] <= DEF_DIV;
        shd_q[k] <= DEF_DIV;
      end
    end else begin
      pend_q <= pend_d;
      tick_q <= tick_d;
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_q[k] <= cnt_d[k];
        act_q[k] <= act_d[k];
        shd_q[k] <= shd_d[k];
      end
    end
  end

  assign tick_o = tick_q;

  // Expose active (never shadow) ratios, channel k at bits [k*DIV_W +: DIV_W].
  for (genvar g = 0; g < NUM_CH; g++) begin : g_div
    assign div_o[g*DIV_W +: DIV_W] = act_q[g];
  end

`ifdef TICK_SCHED_CFG_CHK_EN
  logic cfg_in_range;
  logic err_q;
  logic err_d;

  // Flag an accepted write whose channel index does not exist.
  always_comb begin
    cfg_in_range = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cfg_ch_i == CH_W'(k)) begin
        cfg_in_range = 1'b1;
      end
    end
    err_d = cfg_xfer && !cfg_in_range;
  end

  // One-cycle error pulse following the dropped write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign cfg_err_o = err_q;
`endif

endmodule
